// File: rtl/sprite_line_engine.sv
// sprite_line_engine: scanline sprite compositor into a double-buffered, clear-on-read line buffer.
// Define SPRITE_COLLISION_EN to add per-entry owner tracking and the collide_mask output.
module sprite_line_engine #(
   parameter int NUM_SPRITES = 8,
   parameter int SPRITE_SIZE = 16,
   parameter int LINE_WIDTH  = 224,
   parameter int ROM_AW      = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       line_start,
   input  logic [7:0]                 next_row,
   input  logic [NUM_SPRITES*8-1:0]   spr_x,
   input  logic [NUM_SPRITES*8-1:0]   spr_y,
   input  logic [NUM_SPRITES*6-1:0]   spr_num,
   input  logic [NUM_SPRITES-1:0]     spr_xflip,
   input  logic [NUM_SPRITES-1:0]     spr_yflip,
   input  logic [NUM_SPRITES*32-1:0]  spr_palette,
   output logic                       rom_rd_en,
   output logic [ROM_AW-1:0]          rom_addr,
   input  logic [7:0]                 rom_data,
   input  logic                       pix_rd,
   input  logic [7:0]                 pix_col,
   output logic                       pix_valid,
   output logic [3:0]                 pix_color,
   output logic                       busy,
   output logic                       overrun
`ifdef SPRITE_COLLISION_EN
   ,output logic [NUM_SPRITES-1:0]    collide_mask
`endif
);
   localparam int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
`ifdef SPRITE_COLLISION_EN
   localparam int EW = 5 + IW;
`else
   localparam int EW = 5;
`endif
   localparam logic [8:0] LW = 9'(LINE_WIDTH);
   typedef enum logic [2:0] {CLEAR, IDLE, SCAN, FETCH, WAIT, WRITE, NEXT} state_t;
   state_t state;
   logic [IW-1:0] idx;
   logic [7:0] row, data, sx, sy;
   logic [1:0] q, k, fq, off, pix;
   logic [5:0] sn;
   logic [31:0] pal;
   logic [3:0] r, color;
   logic [8:0] clr, col;
   logic bsel, xf, yf, hit, wr_en, rd_ok;
   logic [4:0] rd_entry;
   logic [ROM_AW-1:0] addr;
   logic [EW-1:0] wr_val;
   logic [EW-1:0] mem0 [LINE_WIDTH];
   logic [EW-1:0] mem1 [LINE_WIDTH];
`ifdef SPRITE_COLLISION_EN
   logic [EW-1:0] cur;
`endif
   assign busy = state != IDLE;
   // 15-x on a 4-bit field is ~x, so flips are plain XORs
   always_comb begin
      sx = spr_x[idx*8 +: 8];
      sy = spr_y[idx*8 +: 8];
      sn = spr_num[idx*6 +: 6];
      xf = spr_xflip[idx];
      yf = spr_yflip[idx];
      pal = spr_palette[idx*32 +: 32];
      hit = {1'b0, row} >= {1'b0, sy} && {1'b0, row} < {1'b0, sy} + 9'(SPRITE_SIZE);
      r = (row[3:0] - sy[3:0]) ^ {4{yf}};
      fq = state == SCAN ? 2'd0 : q + 2'd1;
      addr = ROM_AW'({sn, r, fq ^ {2{xf}}});
      off = k ^ {2{xf}};
      pix = data[{off, 1'b0} +: 2];
      color = pal[{~pix, 3'b000} +: 4];
      col = {1'b0, sx} + {5'd0, q, k};
      wr_en = state == WRITE && pix != 2'd0 && col < LW;
      rd_ok = pix_rd && {1'b0, pix_col} < LW && state != CLEAR;
      rd_entry = bsel ? mem0[pix_col][4:0] : mem1[pix_col][4:0];
`ifdef SPRITE_COLLISION_EN
      cur = bsel ? mem1[col[7:0]] : mem0[col[7:0]];
      wr_val = {idx, 1'b1, color};
`else
      wr_val = {1'b1, color};
`endif
   end
   // build writes bank bsel, display reads and clears the other one
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem0[clr[7:0]] <= '0;
         mem1[clr[7:0]] <= '0;
      end else begin
         if (wr_en && !bsel) mem0[col[7:0]] <= wr_val;
         if (wr_en && bsel) mem1[col[7:0]] <= wr_val;
         if (rd_ok && bsel) mem0[pix_col] <= '0;
         if (rd_ok && !bsel) mem1[pix_col] <= '0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         clr <= '0;
         idx <= '0;
         row <= '0;
         q <= '0;
         k <= '0;
         data <= '0;
         bsel <= 1'b0;
         rom_rd_en <= 1'b0;
         rom_addr <= '0;
         overrun <= 1'b0;
         pix_valid <= 1'b0;
         pix_color <= '0;
`ifdef SPRITE_COLLISION_EN
         collide_mask <= '0;
`endif
      end else begin
         overrun <= line_start && busy;
         rom_rd_en <= 1'b0;
         if (pix_rd) {pix_valid, pix_color} <= rd_ok ? rd_entry : 5'd0;
         // the reset sweep cannot be aborted, so line_start then only flags overrun
         if (line_start && state != CLEAR) begin
            bsel <= ~bsel;
            row <= next_row;
            idx <= IW'(NUM_SPRITES - 1);
            state <= SCAN;
`ifdef SPRITE_COLLISION_EN
            collide_mask <= '0;
`endif
         end else begin
            case (state)
               CLEAR: begin
                  clr <= clr + 9'd1;
                  if (clr == LW - 9'd1) state <= IDLE;
               end
               SCAN: begin
                  q <= 2'd0;
                  rom_rd_en <= hit;
                  rom_addr <= hit ? addr : rom_addr;
                  state <= hit ? FETCH : NEXT;
               end
               FETCH: state <= WAIT;
               WAIT: begin
                  data <= rom_data;
                  k <= 2'd0;
                  state <= WRITE;
               end
               WRITE: begin
                  k <= k + 2'd1;
`ifdef SPRITE_COLLISION_EN
                  if (wr_en && cur[4]) begin
                     collide_mask[idx] <= 1'b1;
                     collide_mask[cur[EW-1:5]] <= 1'b1;
                  end
`endif
                  if (k == 2'd3) begin
                     q <= fq;
                     rom_rd_en <= q != 2'd3;
                     rom_addr <= q != 2'd3 ? addr : rom_addr;
                     state <= q != 2'd3 ? FETCH : NEXT;
                  end
               end
               NEXT: begin
                  idx <= idx == '0 ? idx : idx - 1'b1;
                  state <= idx == '0 ? IDLE : SCAN;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine: directed scenarios for sprite_line_engine with hand-computed expectations.
module tb_sprite_line_engine;
   localparam int NS = 8;
   logic clk = 0, rst = 1, line_start = 0, pix_rd = 0;
   logic [7:0] next_row = 0, pix_col = 0, rom_data = 0;
   logic [NS*8-1:0] spr_x = 0, spr_y = 0;
   logic [NS*6-1:0] spr_num = 0;
   logic [NS-1:0] spr_xflip = 0, spr_yflip = 0;
   logic [NS*32-1:0] spr_palette = 0;
   logic rom_rd_en, pix_valid, busy, overrun;
   logic [11:0] rom_addr;
   logic [3:0] pix_color;
`ifdef SPRITE_COLLISION_EN
   logic [NS-1:0] collide_mask;
`endif
   int checks = 0, errors = 0;
   int rom_mode = 0, log_start = 0, nreads = 0, sreads = 0, cnt = 0;
   logic [11:0] addr_log[$];
   logic [11:0] sfirst;
   logic vl [0:223];
   logic [3:0] cl [0:223];
   logic v;
   logic [3:0] c;

   sprite_line_engine #(.NUM_SPRITES(NS)) dut (
      .clk(clk), .rst(rst), .line_start(line_start), .next_row(next_row),
      .spr_x(spr_x), .spr_y(spr_y), .spr_num(spr_num), .spr_xflip(spr_xflip),
      .spr_yflip(spr_yflip), .spr_palette(spr_palette), .rom_rd_en(rom_rd_en),
      .rom_addr(rom_addr), .rom_data(rom_data), .pix_rd(pix_rd), .pix_col(pix_col),
      .pix_valid(pix_valid), .pix_color(pix_color), .busy(busy), .overrun(overrun)
`ifdef SPRITE_COLLISION_EN
      , .collide_mask(collide_mask)
`endif
   );

   always #5 clk = ~clk;

   // ROM model: data one cycle after the strobe; mode 1 makes only pixel column 0 of each row nonzero
   always @(posedge clk) begin
      if (rom_rd_en) begin
         addr_log.push_back(rom_addr);
         rom_data <= rom_mode == 0 ? 8'h55 : (rom_addr[1:0] == 2'd0 ? 8'h01 : 8'h00);
      end
   end

   task automatic set_spr(input int i, input logic [7:0] x, input logic [7:0] y, input logic [5:0] n,
                          input logic xf, input logic yf, input logic [31:0] pal);
      spr_x[i*8 +: 8] = x;
      spr_y[i*8 +: 8] = y;
      spr_num[i*6 +: 6] = n;
      spr_xflip[i] = xf;
      spr_yflip[i] = yf;
      spr_palette[i*32 +: 32] = pal;
   endtask

   task automatic park();
      spr_x = '0;
      spr_y = {NS{8'd240}};
      spr_num = '0;
      spr_xflip = '0;
      spr_yflip = '0;
      spr_palette = '0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
      if (busy) begin
         errors++;
         $display("FAIL build_timeout: busy still %b after 1000 cycles, want 0", busy);
      end
      nreads = addr_log.size() - log_start;
   endtask

   task automatic build(input logic [7:0] r);
      @(negedge clk);
      next_row = r;
      line_start = 1;
      @(negedge clk);
      line_start = 0;
      log_start = addr_log.size();
      wait_idle();
   endtask

   task automatic read_one(input logic [7:0] col, output logic ov, output logic [3:0] oc);
      @(negedge clk);
      pix_rd = 1;
      pix_col = col;
      @(negedge clk);
      pix_rd = 0;
      ov = pix_valid;
      oc = pix_color;
   endtask

   task automatic read_line();
      cnt = 0;
      for (int i = 0; i < 224; i++) begin
         read_one(8'(i), vl[i], cl[i]);
         if (vl[i] === 1'b1) cnt++;
      end
   endtask

   task automatic swap_out();
      sreads = nreads;
      sfirst = nreads > 0 ? addr_log[log_start] : 12'hfff;
      park();
      build(8'd239);
      read_line();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst = 0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
      checks++;
      if ({rom_rd_en, overrun, pix_valid, pix_color} !== 7'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 0000000", {rom_rd_en, overrun, pix_valid, pix_color});
      end
      log_start = addr_log.size();
      wait_idle();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_fall: got %b want 0", busy); end
      read_line();
      checks++;
      if (cnt != 0) begin errors++; $display("FAIL reset_empty: got %0d valid cols want 0", cnt); end
      checks++;
      if (addr_log.size() != 0) begin errors++; $display("FAIL reset_rom: got %0d reads want 0", addr_log.size()); end
   endtask

   task automatic test_basic();
      park();
      rom_mode = 0;
      set_spr(3, 8'd10, 8'd20, 6'd9, 0, 0, 32'h0007_0000);
      build(8'd25);
      swap_out();
      checks++;
      if (sreads != 4) begin errors++; $display("FAIL basic_reads: got %0d want 4", sreads); end
      checks++;
      if (sfirst !== 12'd596) begin errors++; $display("FAIL basic_addr: got %0d want 596", sfirst); end
      checks++;
      if (cnt != 16) begin errors++; $display("FAIL basic_count: got %0d want 16", cnt); end
      cnt = 0;
      for (int i = 10; i <= 25; i++) if (vl[i] === 1'b1 && cl[i] === 4'd7) cnt++;
      checks++;
      if (cnt != 16) begin errors++; $display("FAIL basic_cols: got %0d good cols want 16", cnt); end
      checks++;
      if (vl[9] !== 1'b0 || vl[26] !== 1'b0) begin
         errors++;
         $display("FAIL basic_edges: got col9=%b col26=%b want 0 0", vl[9], vl[26]);
      end
      read_one(8'd10, v, c);
      checks++;
      if ({v, c} !== 5'd0) begin errors++; $display("FAIL basic_clear_on_read: got %b/%h want 0/0", v, c); end
   endtask

   task automatic test_priority();
      park();
      rom_mode = 0;
      set_spr(0, 8'd50, 8'd60, 6'd1, 0, 0, 32'h0003_0000);
      set_spr(1, 8'd50, 8'd60, 6'd2, 0, 0, 32'h000C_0000);
      build(8'd62);
`ifdef SPRITE_COLLISION_EN
      checks++;
      if (collide_mask !== 8'h03) begin errors++; $display("FAIL prio_collide: got %h want 03", collide_mask); end
`endif
      swap_out();
      checks++;
      if (sreads != 8) begin errors++; $display("FAIL prio_reads: got %0d want 8", sreads); end
      cnt = 0;
      for (int i = 50; i <= 65; i++) if (vl[i] === 1'b1 && cl[i] === 4'd3) cnt++;
      checks++;
      if (cnt != 16) begin errors++; $display("FAIL prio_winner: got %0d cols of color 3 want 16", cnt); end
   endtask

   task automatic test_flip();
      park();
      rom_mode = 1;
      set_spr(2, 8'd100, 8'd30, 6'd5, 1, 0, 32'h0009_0000);
      build(8'd33);
      swap_out();
      checks++;
      if (sfirst !== 12'd335) begin errors++; $display("FAIL xflip_addr: got %0d want 335", sfirst); end
      checks++;
      if (cnt != 1) begin errors++; $display("FAIL xflip_count: got %0d want 1", cnt); end
      checks++;
      if (vl[115] !== 1'b1 || cl[115] !== 4'd9) begin
         errors++;
         $display("FAIL xflip_col115: got %b/%h want 1/9", vl[115], cl[115]);
      end
      park();
      set_spr(2, 8'd100, 8'd30, 6'd5, 0, 1, 32'h0009_0000);
      build(8'd33);
      swap_out();
      checks++;
      if (sfirst !== 12'd368) begin errors++; $display("FAIL yflip_addr: got %0d want 368", sfirst); end
      checks++;
      if (cnt != 1 || vl[100] !== 1'b1) begin
         errors++;
         $display("FAIL yflip_col100: got count %0d col100 %b want 1 1", cnt, vl[100]);
      end
   endtask

   task automatic test_edge();
      park();
      rom_mode = 0;
      set_spr(4, 8'd216, 8'd80, 6'd0, 0, 0, 32'h000A_0000);
      build(8'd85);
      swap_out();
      checks++;
      if (cnt != 8) begin errors++; $display("FAIL edge_count: got %0d want 8", cnt); end
      checks++;
      if (vl[223] !== 1'b1 || cl[223] !== 4'hA || vl[216] !== 1'b1) begin
         errors++;
         $display("FAIL edge_last: got col216=%b col223=%b/%h want 1 1/a", vl[216], vl[223], cl[223]);
      end
      checks++;
      if (vl[0] !== 1'b0) begin errors++; $display("FAIL edge_nowrap: got col0=%b want 0", vl[0]); end
      set_spr(4, 8'd216, 8'd80, 6'd0, 0, 0, 32'h000A_0000);
      build(8'd96);
      checks++;
      if (nreads != 0) begin errors++; $display("FAIL edge_row_past: got %0d reads want 0", nreads); end
   endtask

   task automatic test_back_to_back();
      park();
      rom_mode = 0;
      for (int i = 0; i < NS; i++) set_spr(i, 8'(i * 20), 8'd100, 6'(i + 1), 0, 0, 32'((i + 1) << 16));
      @(negedge clk);
      next_row = 8'd105;
      line_start = 1;
      @(negedge clk);
      line_start = 0;
      repeat (100) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL ovr_busy: got %b want 1", busy); end
      line_start = 1;
      @(negedge clk);
      line_start = 0;
      log_start = addr_log.size();
      checks++;
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
      @(negedge clk);
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pulse_end: got %b want 0", overrun); end
      wait_idle();
      checks++;
      if (nreads != 32 || addr_log[log_start] !== 12'd532) begin
         errors++;
         $display("FAIL ovr_restart: got %0d reads first %0d want 32 532", nreads, addr_log[log_start]);
      end
      read_one(8'd140, v, c);
      checks++;
      if ({v, c} !== 5'h18) begin errors++; $display("FAIL ovr_partial_col140: got %b/%h want 1/8", v, c); end
      read_one(8'd0, v, c);
      checks++;
      if (v !== 1'b0) begin errors++; $display("FAIL ovr_partial_col0: got %b want 0", v); end
   endtask

   initial begin
      park();
      test_reset();
      test_basic();
      test_priority();
      test_flip();
      test_edge();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
